// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  // Width of the nibble index for a given operand width (never below one bit).
  function automatic int idx_width(input int width);
    return (width / NIB_W > 1) ? $clog2(width / NIB_W) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Operand/result handshake bundle; zero/ovf exist only when ADDSUB_FLAGS_EN is defined.
interface nibble_serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef ADDSUB_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, cout, zero, ovf
  );
  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, cout, zero, ovf
  );
`else
  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, cout
  );
  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, cout
  );
`endif
endinterface

// File: rtl/nibble_serial_addsub_nibble_adder.sv
// Combinational 4-bit add/sub slice: s = x + (y ^ {4{sub}}) + cin, with carry into bit 3.
module nibble_adder
  import addsub_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             sub,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             co,
  output logic             c3
);

  logic [NIB_W-1:0] y_eff;
  logic [NIB_W-2:0] low_sum;

  always_comb begin
    y_eff = y ^ {NIB_W{sub}};
    // Carry into the top bit comes from the sum of the three low bits alone.
    {c3, low_sum} = {1'b0, x[NIB_W-2:0]} + {1'b0, y_eff[NIB_W-2:0]} + {{(NIB_W-1){1'b0}}, cin};
    {co, s}       = {1'b0, x} + {1'b0, y_eff} + {{NIB_W{1'b0}}, cin};
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/sub computed one nibble per cycle through a shared 4-bit slice.
// Optional zero/ovf flags are built when ADDSUB_FLAGS_EN is defined.
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_addsub_if.slave bus
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   result_q, result_d;
`ifdef ADDSUB_FLAGS_EN
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
`endif

  logic               accept;
  logic               run_step;
  logic               last_nib;
  logic [NIB_W-1:0]   a_nib [NIB];
  logic [NIB_W-1:0]   b_nib [NIB];
  logic [NIB_W-1:0]   sum_nib;
  logic               slice_co;
  logic               slice_c3;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign run_step = (state_q == RUN);
  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  // Operand nibble views and per-nibble result write-back.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
    assign a_nib[gi] = a_q[gi*NIB_W +: NIB_W];
    assign b_nib[gi] = b_q[gi*NIB_W +: NIB_W];
    assign result_d[gi*NIB_W +: NIB_W] =
        (run_step && idx_q == IDX_W'(gi)) ? sum_nib : result_q[gi*NIB_W +: NIB_W];
  end

  nibble_adder u_slice (
    .x   (a_nib[idx_q]),
    .y   (b_nib[idx_q]),
    .sub (sub_q),
    .cin (carry_q),
    .s   (sum_nib),
    .co  (slice_co),
    .c3  (slice_c3)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_nib)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      sub_d   = bus.op_sub;
      carry_d = bus.op_sub;   // +1 of the two's-complement negate enters as the first carry
      idx_d   = '0;
    end else if (run_step) begin
      carry_d = slice_co;
      idx_d   = last_nib ? '0 : idx_q + 1'b1;
    end
  end

`ifdef ADDSUB_FLAGS_EN
  always_comb begin
    zero_d = zero_q;
    ovf_d  = ovf_q;
    if (run_step && last_nib) begin
      zero_d = (result_d == '0);
      ovf_d  = slice_c3 ^ slice_co;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
`ifdef ADDSUB_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
`ifdef ADDSUB_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // After the last nibble the carry flop holds the final carry out until the next accept.
  assign bus.result = result_q;
  assign bus.cout   = carry_q;
`ifdef ADDSUB_FLAGS_EN
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub (WIDTH=16); flag checks follow ADDSUB_FLAGS_EN.
module tb_nibble_serial_addsub;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_serial_addsub_if #(.WIDTH(W)) bus ();

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   prev_bb = -1;
  bit   bb_mode = 1'b0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-word arithmetic, unsigned compare for borrow, signed range for overflow.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub);
    exp_t e;
    logic [W:0] full;
    longint sa, sbv, sr;
    sa  = longint'($signed(av));
    sbv = longint'($signed(bv));
    if (sub) begin
      full = {1'b0, av} - {1'b0, bv};
      e.c  = (av >= bv);
      sr   = sa - sbv;
    end else begin
      full = {1'b0, av} + {1'b0, bv};
      e.c  = full[W];
      sr   = sa + sbv;
    end
    e.r = full[W-1:0];
    e.z = (e.r == '0);
    e.v = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard push on every accepted request.
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) begin
      sb.push_back(model(bus.a, bus.b, bus.op_sub));
      if (bb_mode && prev_bb >= 0) check("accept_interval", 32'(cyc - prev_bb), 32'(NIB + 2));
      if (bb_mode) prev_bb = cyc;
      last_acc = cyc;
      $display("[%0d] accept a=%h b=%h sub=%0d", cyc, bus.a, bus.b, bus.op_sub);
    end
  end

  // Monitor: latency of out_valid and result comparison on transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) check("latency", 32'(cyc - last_acc), 32'(NIB + 1));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected none", bus.result);
        end else begin
          e = sb.pop_front();
          check("result", 32'(bus.result), 32'(e.r));
          check("cout", 32'(bus.cout), 32'(e.c));
`ifdef ADDSUB_FLAGS_EN
          check("zero", 32'(bus.zero), 32'(e.z));
          check("ovf", 32'(bus.ovf), 32'(e.v));
`endif
          $display("[%0d] result=%h cout=%0d exp=%h/%0d", cyc, bus.result, bus.cout, e.r, e.c);
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    bit ok = 1'b0;
    bus.a = av; bus.b = bv; bus.op_sub = s; bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_xfer();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) ok = 1'b1;
    end
    if (!ok) check("xfer_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_cout"}, 32'(bus.cout), 32'd0);
`ifdef ADDSUB_FLAGS_EN
    check({tag, "_zero"}, 32'(bus.zero), 32'd0);
    check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] snap_r;
    logic         snap_c;
    bit           ok;

    bus.in_valid = 1'b0; bus.op_sub = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed operations
    send(16'h1234, 16'h0FED, 1'b0); wait_xfer();
    check("t1_result", 32'(bus.result), 32'h2221);
    check("t1_cout", 32'(bus.cout), 32'd0);
    send(16'h0005, 16'h0007, 1'b1); wait_xfer();
    check("t2_result", 32'(bus.result), 32'hFFFE);
    check("t2_cout", 32'(bus.cout), 32'd0);
    send(16'hFFFF, 16'h0001, 1'b0); wait_xfer();
    check("t3_result", 32'(bus.result), 32'h0000);
    check("t3_cout", 32'(bus.cout), 32'd1);
`ifdef ADDSUB_FLAGS_EN
    check("t3_zero", 32'(bus.zero), 32'd1);
`endif
    send(16'h7FFF, 16'h0001, 1'b0); wait_xfer();
    check("t3b_result", 32'(bus.result), 32'h8000);
`ifdef ADDSUB_FLAGS_EN
    check("t3b_ovf", 32'(bus.ovf), 32'd1);
`endif

    // Backpressure: result held, second request ignored
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1'b1;
    end
    if (!ok) check("bp_valid_timeout", 32'd1, 32'd0);
    snap_r = bus.result; snap_c = bus.cout;
    check("bp_snap_result", 32'(snap_r), 32'h3333);
    @(posedge clk); #1;
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.op_sub = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result", 32'(bus.result), 32'(snap_r));
      check("bp_cout", 32'(bus.cout), 32'(snap_c));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    wait_xfer();

    // Reset while in RUN with idx=2
    send(16'hABCD, 16'h1234, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(16'h0001, 16'h0001, 1'b0); wait_xfer();
    check("t5_result", 32'(bus.result), 32'h0002);

    // Back-to-back random traffic
    bb_mode = 1'b1; prev_bb = -1;
    bus.out_ready = 1'b1;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.op_sub = 1'($urandom);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        if (bus.in_ready) ok = 1'b1;
      end
      if (!ok) check("bb_accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.op_sub = 1'($urandom);
    end
    bus.in_valid = 1'b0;
    wait_xfer();
    bb_mode = 1'b0;
    repeat (3) @(posedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
